// File: rtl/multi_divider.sv
// multi_divider: N-channel programmable clock divider with a one-deep divisor write slot.
// Defining MULTI_DIVIDER_TICK_EN builds the registered per-channel end-of-period tick.
module multi_divider_lane #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    input  logic             hit,
    input  logic [WIDTH-1:0] new_div,
    output logic             commit,
    output logic             clk_out,
    output logic             tick
);
    logic [WIDTH-1:0] cnt, cnt_n, div_q, d_eff;
    logic             run, clk_r, clk_n, slow, wrap;

    assign slow   = (div_q <= WIDTH'(1));
    assign wrap   = !slow && (cnt >= div_q - WIDTH'(1));
    // A new divisor only lands where a period would start anyway, so no runt phases.
    assign commit = hit && (!enable || restart || slow || wrap);
    assign d_eff  = commit ? new_div : div_q;

    always_comb begin
        cnt_n = '0;
        // run low marks the first enabled edge: that edge loads 0 rather than counting.
        if (enable && run && !restart && !commit && !slow && !wrap)
            cnt_n = cnt + WIDTH'(1);
        clk_n = enable && (d_eff >= WIDTH'(2)) && (cnt_n >= (d_eff >> 1));
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= WIDTH'(DEFAULT_DIV);
            run   <= 1'b0;
            clk_r <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            run   <= enable;
            clk_r <= clk_n;
            if (commit)
                div_q <= new_div;
        end
    end

    // Divide-by-one keeps the legacy combinational pass-through.
    assign clk_out = (div_q == WIDTH'(1)) ? (clk_in & enable) : clk_r;

`ifdef MULTI_DIVIDER_TICK_EN
    logic tick_r, tick_n;

    assign tick_n = enable && (d_eff >= WIDTH'(2)) && (cnt_n == d_eff - WIDTH'(1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            tick_r <= 1'b0;
        else
            tick_r <= tick_n;
    end

    assign tick = tick_r;
`else
    assign tick = 1'b0;
`endif
endmodule

module multi_divider #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] enable,
    input  logic                restart,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);
    typedef struct packed {
        logic [CW-1:0]    chan;
        logic [WIDTH-1:0] div;
    } slot_t;

    slot_t               pend;
    logic                pend_vld, accept, discard;
    logic [CHANNELS-1:0] hit, commit;

    assign cfg_ready = !pend_vld;
    assign accept    = cfg_valid && cfg_ready;
    // A slot that matches no lane targets a channel that does not exist; drop it.
    assign discard   = pend_vld && !(|hit);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend     <= '0;
        end else if (accept) begin
            pend_vld <= 1'b1;
            pend     <= '{chan: cfg_chan, div: cfg_div};
        end else if (discard || (|commit)) begin
            pend_vld <= 1'b0;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign hit[c] = pend_vld && (pend.chan == CW'(c));

        multi_divider_lane #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_lane (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .enable  (enable[c]),
            .restart (restart),
            .hit     (hit[c]),
            .new_div (pend.div),
            .commit  (commit[c]),
            .clk_out (clk_out[c]),
            .tick    (tick[c])
        );
    end
endmodule

// File: tb/tb_multi_divider.sv
// Randomized self-checking bench for multi_divider against a period-arithmetic reference model.
`timescale 1ns/1ps
module tb_multi_divider;
    localparam int CH = 4;
`ifdef MULTI_DIVIDER_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic          clk_in = 1'b0, rst_n = 1'b0, restart = 1'b0, cfg_valid = 1'b0;
    logic [CH-1:0] enable = '0;
    logic [1:0]    cfg_chan = '0;
    logic [7:0]    cfg_div = '0;
    logic [CH-1:0] clk_out, tick;
    logic          cfg_ready;

    logic [2:0] en3 = 3'b111, co3, tk3;
    logic       rs3 = 1'b0, cv3 = 1'b0, rdy3;
    logic [1:0] cc3 = '0;
    logic [7:0] cd3 = '0;

    int npass = 0, ntot = 0;

    // Reference model: period origin age and divisor per channel, one pending slot.
    int mD[CH], mage[CH];
    bit mrun[CH];
    bit sv, sv3;
    int schan, sdiv, n3;

    always #5 clk_in = ~clk_in;

    multi_divider #(.CHANNELS(CH), .WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .restart(restart),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick));

    multi_divider #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(2)) dut3 (
        .clk_in(clk_in), .rst_n(rst_n), .enable(en3), .restart(rs3),
        .cfg_valid(cv3), .cfg_ready(rdy3), .cfg_chan(cc3),
        .cfg_div(cd3), .clk_out(co3), .tick(tk3));

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            mD[i] = 2; mage[i] = 0; mrun[i] = 0;
        end
        sv = 0; sv3 = 0; n3 = 0;
    endtask

    task automatic step();
        bit acc, hitc, wrp, com, any;
        @(posedge clk_in);
        acc = cfg_valid && !sv;
        any = 0;
        for (int i = 0; i < CH; i++) begin
            hitc = sv && (schan == i);
            wrp  = enable[i] && mD[i] >= 2 && (mage[i] % mD[i]) == mD[i] - 1;
            com  = hitc && (!enable[i] || restart || mD[i] <= 1 || wrp);
            if (com) begin mD[i] = sdiv; any = 1; end
            if (!enable[i]) begin mage[i] = 0; mrun[i] = 0; end
            else if (!mrun[i] || restart || com) begin mage[i] = 0; mrun[i] = 1; end
            else mage[i]++;
        end
        if (sv && (any || schan >= CH)) sv = 0;
        if (acc) begin sv = 1; schan = int'(cfg_chan); sdiv = int'(cfg_div); end
        if (sv3) sv3 = 0; else if (cv3) sv3 = 1;
        n3++;
        #1;
    endtask

    function automatic logic [8:0] expv();
        logic [3:0] c, t;
        c = '0; t = '0;
        for (int i = 0; i < CH; i++) begin
            if (mD[i] == 1) c[i] = clk_in & enable[i];
            else if (mrun[i] && mD[i] >= 2) begin
                c[i] = (mage[i] % mD[i]) >= mD[i] / 2;
                t[i] = TICK_ON && ((mage[i] % mD[i]) == mD[i] - 1);
            end
        end
        return {c, t, ~sv};
    endfunction

    function automatic logic [6:0] expv3();
        logic ph;
        ph = (n3 > 0) && (n3 % 2 == 0);
        return {{3{ph}}, {3{ph & TICK_ON}}, ~sv3};
    endfunction

    task automatic write(input int ch, input int dv);
        for (int k = 0; k < 64 && sv; k++) step();
        cfg_valid = 1'b1; cfg_chan = ch[1:0]; cfg_div = dv[7:0];
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        ntot++;
        if ({clk_out, tick, cfg_ready} !== 9'b0000_0000_1)
            $display("FAIL reset: got %b want %b", {clk_out, tick, cfg_ready}, 9'b0000_0000_1);
        else npass++;
        @(negedge clk_in);
        model_reset();
        enable = '1;
        rst_n  = 1'b1;
    endtask

    task automatic test_default();
        for (int i = 0; i < 8; i++) begin
            step();
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL default cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
        end
    endtask

    task automatic test_write_ch1();
        write(1, 5);
        for (int i = 0; i < 20; i++) begin
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL write_ch1 cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
            step();
        end
    endtask

    task automatic test_passthru();
        write(2, 1);
        write(3, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL passthru_hi cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
            @(negedge clk_in); #1;
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL passthru_lo cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
        end
    endtask

    task automatic test_restart();
        int n;
        write(0, 7);
        write(1, 3);
        n = $urandom_range(4, 12);
        for (int i = 0; i < n; i++) begin
            step();
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL restart_pre cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        ntot++;
        if (clk_out[1:0] !== 2'b00)
            $display("FAIL restart_fall: got %b want 00", clk_out[1:0]);
        else npass++;
        for (int i = 0; i < 10; i++) begin
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL restart_post cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
            step();
        end
    endtask

    task automatic test_discard();
        cv3 = 1'b1; cc3 = 2'd3; cd3 = 8'd5;
        step();
        cv3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ntot++;
            if ({co3, tk3, rdy3} !== expv3())
                $display("FAIL discard cyc%0d: got %b want %b", i, {co3, tk3, rdy3}, expv3());
            else npass++;
            step();
        end
    endtask

    task automatic test_random();
        int b;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                b = $urandom_range(0, CH - 1);
                enable[b] = ~enable[b];
            end
            restart   = ($urandom_range(0, 19) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_div   = 8'($urandom_range(0, 9));
            step();
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL random cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
        end
        restart = 1'b0; cfg_valid = 1'b0; enable = '1;
    endtask

    task automatic test_async_reset();
        write(0, 6);
        write(0, 8);
        #3;
        rst_n = 1'b0;
        #1;
        ntot++;
        if ({clk_out, tick, cfg_ready, co3, rdy3} !== 13'b0000_0000_1_000_1)
            $display("FAIL async_reset: got %b want %b", {clk_out, tick, cfg_ready, co3, rdy3},
                     13'b0000_0000_1_000_1);
        else npass++;
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL post_reset cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
        end
        write(0, 4);
        for (int i = 0; i < 16; i++) begin
            step();
            ntot++;
            if ({clk_out, tick, cfg_ready} !== expv())
                $display("FAIL tick_d4 cyc%0d: got %b want %b", i, {clk_out, tick, cfg_ready}, expv());
            else npass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default();
        test_write_ch1();
        test_passthru();
        test_restart();
        test_discard();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
